inst_rom_arbiter: RTL and testbench

Two-port arbiter that shares the single-port, combinational-read instruction ROM between the CPU fetch port (port 0) and a debug/loader read port (port 1). It sits between `NJU_MIPS`/debug logic and `inst_rom`. It drives the ROM `ce`/`addr` from the winning requester and registers the returned word back to that requester one cycle later. Port 0 has fixed priority, and a starvation counter guarantees bounded latency for port 1.

---
 rtl/inst_rom_arbiter.sv | 81 ++++++++
 tb/tb_inst_rom_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter sharing a combinational-read instruction ROM between the CPU fetch port
// and a debug/loader port. Fixed priority to port 0, with bounded wait for port 1.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              force_c;
  logic              starved_c;

  // Port 1 is forced through once it has been denied STARVE_LIMIT cycles in a row.
  assign starved_c = (32'(wait_cnt) >= STARVE_LIMIT);
  assign force_c   = m1_req && starved_c;
  assign m1_gnt    = m1_req && (force_c || !m0_req);
  assign m0_gnt    = m0_req && !m1_gnt;

  assign rom_ce   = m0_gnt | m1_gnt;
  assign rom_addr = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);

  // The owner of a pending response gets the valid pulse in the following cycle.
  assign m0_rvalid = (state_q == RESP) && !owner_q;
  assign m1_rvalid = (state_q == RESP) && owner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wait_cnt <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rom_ce) begin
        state_q <= RESP;
        owner_q <= m1_gnt;
      end else begin
        state_q <= IDLE;
      end

      if (m0_gnt) rdata0_q <= rom_data;
      if (m1_gnt) rdata1_q <= rom_data;

      // Saturating count of consecutive denied port-1 cycles; no credit survives a dropped request.
      if (!m1_req || m1_gnt) begin
        wait_cnt <= '0;
      end else if (!starved_c) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: directed vector table, hand-written reset
// sequences and randomized traffic checked against a behavioural arbitration model.
module tb_inst_rom_arbiter;

  localparam int unsigned L = 4;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  logic [31:0] rom_mem [0:63];

  int tests;
  int fails;

  // Behavioural model state
  int          denied;
  logic [31:0] exp_d0;
  logic [31:0] exp_d1;
  logic        seen_g0;
  logic        seen_g1;

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        g0;
    logic        g1;
  } vec_t;

  vec_t vecs[$];

  inst_rom_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(L), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  assign rom_data = rom_ce ? rom_mem[rom_addr[7:2]] : 32'h0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive requests, check grants/ROM drive, then check the responses.
  task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1);
    logic        win1;
    logic        win0;
    logic [31:0] exp_addr;
    m0_req  = r0;
    m0_addr = a0;
    m1_req  = r1;
    m1_addr = a1;
    #3;
    // Debug port wins when the CPU is idle or it has waited its full allowance.
    win1 = r1 && (!r0 || denied >= int'(L));
    win0 = r0 && !win1;
    exp_addr = win1 ? a1 : (win0 ? a0 : 32'h0);
    chk("m0_gnt", 32'(m0_gnt), 32'(win0));
    chk("m1_gnt", 32'(m1_gnt), 32'(win1));
    chk("rom_ce", 32'(rom_ce), 32'(win0 | win1));
    chk("rom_addr", rom_addr, exp_addr);
    seen_g0 = m0_gnt;
    seen_g1 = m1_gnt;
    if (win0) exp_d0 = rom_mem[a0[7:2]];
    if (win1) exp_d1 = rom_mem[a1[7:2]];
    if (r1 && !win1) denied = (denied + 1 > int'(L)) ? int'(L) : denied + 1;
    else denied = 0;
    @(posedge clk);
    #1;
    chk("m0_rvalid", 32'(m0_rvalid), 32'(win0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(win1));
    chk("m0_rdata", m0_rdata, exp_d0);
    chk("m1_rdata", m1_rdata, exp_d1);
    chk("wait_cnt", 32'(dut.wait_cnt), 32'(denied));
  endtask

  task automatic add(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                     input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.g0 = g0; v.g1 = g1;
    vecs.push_back(v);
  endtask

  initial begin
    logic        starve_seq [12];
    logic        p0;
    logic        p1;
    logic        r0;
    logic        r1;
    logic [31:0] a0;
    logic [31:0] a1;

    clk = 1'b0; rst = 1'b0;
    m0_req = 1'b0; m0_addr = 32'h0; m1_req = 1'b0; m1_addr = 32'h0;
    tests = 0; fails = 0; denied = 0;
    exp_d0 = 32'h0; exp_d1 = 32'h0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    rom_mem[0] = 32'h3401_0001;

    // Reset values
    #2;
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
    chk("rst_rom_ce", 32'(rom_ce), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed vector table
    add(1, 32'h4, 0, 32'h0, 1, 0);
    add(0, 32'h0, 0, 32'h0, 0, 0);
    add(1, 32'h0, 0, 32'h0, 1, 0);
    add(1, 32'h4, 0, 32'h0, 1, 0);
    add(1, 32'h8, 0, 32'h0, 1, 0);
    add(1, 32'hC, 0, 32'h0, 1, 0);
    add(0, 32'h0, 0, 32'h0, 0, 0);
    add(0, 32'h0, 1, 32'h10, 0, 1);
    add(0, 32'h0, 0, 32'h0, 0, 0);
    starve_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) add(1, 32'h40, 1, 32'h80, !starve_seq[i], starve_seq[i]);
    add(1, 32'h44, 0, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 32'h48, 1, 32'h84, i != 4, i == 4);
    add(0, 32'h0, 0, 32'h0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
      chk($sformatf("tbl%0d_m0_gnt", i), 32'(seen_g0), 32'(vecs[i].g0));
      chk($sformatf("tbl%0d_m1_gnt", i), 32'(seen_g1), 32'(vecs[i].g1));
    end

    // Reset asserted while a port-1 response is pending
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h10;
    #3;
    chk("mid_m1_gnt", 32'(m1_gnt), 32'h1);
    rst = 1'b0;
    #1;
    m1_req = 1'b0; m1_addr = 32'h0;
    @(posedge clk); #1;
    chk("mid_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("mid_m1_rdata", m1_rdata, 32'h0);
    chk("mid_m0_rdata", m0_rdata, 32'h0);
    @(posedge clk); #1;
    chk("mid_m1_rvalid2", 32'(m1_rvalid), 32'h0);
    rst = 1'b1;
    denied = 0; exp_d0 = 32'h0; exp_d1 = 32'h0;
    step(1, 32'h0, 0, 32'h0);
    chk("post_rst_m0_rdata", m0_rdata, 32'h3401_0001);
    step(0, 32'h0, 0, 32'h0);

    // Randomized traffic; unserved requesters hold their address
    p0 = 1'b0; p1 = 1'b0; a0 = 32'h0; a1 = 32'h0;
    for (int i = 0; i < 400; i++) begin
      r0 = p0 ? 1'b1 : ($urandom_range(0, 99) < 70);
      r1 = p1 ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 40);
      if (!p0) a0 = 32'($urandom_range(0, 63)) << 2;
      if (!p1) a1 = 32'($urandom_range(0, 63)) << 2;
      step(r0, a0, r1, a1);
      p0 = r0 && !seen_g0;
      p1 = r1 && !seen_g1;
    end
    step(0, 32'h0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
